// File: rtl/rvecc_decode_pipe.sv
// rvecc_decode_pipe
//   Two-stage SEC-DED decoder for a 32-bit word protected by a 7-bit
//   extended Hamming code: six Hamming check bits plus one overall parity bit.
//
//   Code layout: Hamming positions 1..38. Check bit k sits at position 2^k.
//   The data bits din[0..31] fill the remaining positions in ascending order
//   (din[0]=3, din[1]=5, din[2]=6, din[3]=7, din[4]=9, ..., din[31]=38).
//
//   Stage 1 registers the data word, the syndrome and the parity mismatch.
//   Stage 2 registers the corrected word and the error flags.
//
//   Ports
//     clk              sole clock, rising edge
//     rst              synchronous, active-high reset
//     in_valid/in_ready  input handshake, carrying din[31:0] and ecc_in[6:0]
//     out_valid/out_ready output handshake, carrying dout[31:0],
//                        single_ecc_error and double_ecc_error
//     cnt_clr          synchronous clear of both error counters
//     sb_cnt/db_cnt    saturating counts of single- and double-error transfers
//
//   Handshake rule, identical on both sides: a transfer happens in a cycle
//   in which valid and ready are both high at the rising edge. Valid never
//   depends on ready. While out_valid is high and out_ready is low, dout and
//   both flags are held.
//
//   Build option RVECC_ERR_CNT_EN
//     defined:   sb_cnt and db_cnt are real counters and cnt_clr is honoured.
//     undefined: there are no counter flops, sb_cnt and db_cnt are tied to 0,
//                and cnt_clr is ignored.
module rvecc_decode_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      din,
    input  logic [6:0]       ecc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      dout,
    output logic             single_ecc_error,
    output logic             double_ecc_error,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sb_cnt,
    output logic [CNT_W-1:0] db_cnt
);

    // Hamming check bits for a data word. A position holds data when it is
    // not a power of two.
    function automatic logic [5:0] calc_check(input logic [31:0] d);
        logic [5:0] c;
        int         di;
        c  = '0;
        di = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int k = 0; k < 6; k++) begin
                    if (pos[k]) c[k] = c[k] ^ d[di[4:0]];
                end
                di++;
            end
        end
        return c;
    endfunction

    // Flip the data bit found at Hamming position s. When s points at a
    // check-bit position, no data bit changes.
    function automatic logic [31:0] flip_data(input logic [31:0] d, input logic [5:0] s);
        logic [31:0] r;
        int          di;
        r  = d;
        di = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (pos[5:0] == s) r[di[4:0]] = ~r[di[4:0]];
                di++;
            end
        end
        return r;
    endfunction

    // Pipeline control
    logic        s1_valid;
    logic [31:0] s1_din;
    logic [5:0]  s1_syn;
    logic        s1_par;
    logic        s2_load;
    logic        s1_load;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Stage 1: syndrome and parity mismatch
    logic [5:0] syn;
    logic       par;

    assign syn = calc_check(din) ^ ecc_in[5:0];
    assign par = (^din) ^ (^ecc_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_din   <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            s1_din   <= din;
            s1_syn   <= syn;
            s1_par   <= par;
        end
    end

    // Stage 2: error classification and correction
    logic [31:0] corr_din;
    logic        corr_single;
    logic        corr_double;

    always_comb begin
        corr_din    = s1_din;
        corr_single = 1'b0;
        corr_double = 1'b0;
        if (!s1_par) begin
            // A nonzero syndrome with even parity means two bits flipped.
            if (s1_syn != 6'd0) corr_double = 1'b1;
        end else if (s1_syn == 6'd0) begin
            // Only the overall parity bit itself flipped.
            corr_single = 1'b1;
        end else if (s1_syn <= 6'd38) begin
            corr_single = 1'b1;
            corr_din    = flip_data(s1_din, s1_syn);
        end else begin
            // Odd parity, but the syndrome points outside the codeword.
            corr_double = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            dout             <= '0;
            single_ecc_error <= 1'b0;
            double_ecc_error <= 1'b0;
        end else if (s2_load) begin
            out_valid        <= s1_valid;
            dout             <= corr_din;
            single_ecc_error <= corr_single;
            double_ecc_error <= corr_double;
        end
    end

    // Error counters
`ifdef RVECC_ERR_CNT_EN
    logic [CNT_W-1:0] sb_q;
    logic [CNT_W-1:0] db_q;
    logic             out_xfer;

    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
            db_q <= '0;
        end else if (cnt_clr) begin
            // A clear wins over an increment in the same cycle.
            sb_q <= '0;
            db_q <= '0;
        end else if (out_xfer) begin
            if (single_ecc_error && (sb_q != {CNT_W{1'b1}})) sb_q <= sb_q + 1'b1;
            if (double_ecc_error && (db_q != {CNT_W{1'b1}})) db_q <= db_q + 1'b1;
        end
    end

    assign sb_cnt = sb_q;
    assign db_cnt = db_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sb_cnt = '0;
    assign db_cnt = '0;
`endif

endmodule

// File: tb/tb_rvecc_decode_pipe.sv
// tb_rvecc_decode_pipe
//   Directed bench for rvecc_decode_pipe. The driver pushes a hand-computed
//   {double, single, dout} for every accepted word. The monitor pops one
//   entry on every output transfer and tracks the expected counter values.
module tb_rvecc_decode_pipe;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      din = '0;
  logic [6:0]       ecc_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      dout;
  logic             single_ecc_error;
  logic             double_ecc_error;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] sb_cnt;
  logic [CNT_W-1:0] db_cnt;

  int checks = 0;
  int errors = 0;

  logic [33:0]      exp_q[$];
  logic [CNT_W-1:0] exp_sb = '0;
  logic [CNT_W-1:0] exp_db = '0;
  logic             prev_stall = 1'b0;
  logic [33:0]      prev_out = '0;

  rvecc_decode_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .ecc_in(ecc_in), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .single_ecc_error(single_ecc_error),
    .double_ecc_error(double_ecc_error), .cnt_clr(cnt_clr),
    .sb_cnt(sb_cnt), .db_cnt(db_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one word and wait, up to a bounded number of cycles, until it is
  // accepted. Returns just after the rising edge that performed the transfer.
  task automatic send(input logic [31:0] d, input logic [6:0] e,
                      input logic [31:0] exp_d, input logic exp_s, input logic exp_db);
    bit done = 0;
    din = d;
    ecc_in = e;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({exp_db, exp_s, exp_d});
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, {33'd0, out_valid}, 34'd0);
    chk({tag, "_in_ready"}, {33'd0, in_ready}, 34'd1);
    chk({tag, "_dout_flags"}, {double_ecc_error, single_ecc_error, dout}, 34'd0);
    chk({tag, "_sb_cnt"}, {18'd0, sb_cnt}, 34'd0);
    chk({tag, "_db_cnt"}, {18'd0, db_cnt}, 34'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      chk("sb_cnt", {18'd0, sb_cnt}, {18'd0, exp_sb});
      chk("db_cnt", {18'd0, db_cnt}, {18'd0, exp_db});
      if (prev_stall) begin
        chk("stall_valid", {33'd0, out_valid}, 34'd1);
        chk("stall_hold", {double_ecc_error, single_ecc_error, dout}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", dout);
        end else begin
          chk("result", {double_ecc_error, single_ecc_error, dout}, exp_q.pop_front());
        end
`ifdef RVECC_ERR_CNT_EN
        if (single_ecc_error && exp_sb != '1) exp_sb = exp_sb + 1'b1;
        if (double_ecc_error && exp_db != '1) exp_db = exp_db + 1'b1;
`endif
      end
      if (cnt_clr) begin
        exp_sb = '0;
        exp_db = '0;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {double_ecc_error, single_ecc_error, dout};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    // reset
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check_reset_state("reset");

    // latency: accepted at edge k, out_valid visible after edge k+1
    idle(1);
    send(32'h0, 7'h00, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_1", {33'd0, out_valid}, 34'd0);
    @(negedge clk);
    chk("latency_2", {33'd0, out_valid}, 34'd1);
    idle(2);

    // directed decode vectors
    send(32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0); // din[0] flipped
    send(32'h0000_0003, 7'h00, 32'h0000_0003, 1'b0, 1'b1); // s=6, p=0
    send(32'h0000_0000, 7'h40, 32'h0000_0000, 1'b1, 1'b0); // parity bit flipped
    send(32'h0000_0001, 7'h43, 32'h0000_0001, 1'b0, 1'b0); // clean
    send(32'h0000_0000, 7'h01, 32'h0000_0000, 1'b1, 1'b0); // check bit 0 flipped
    send(32'h0000_0000, 7'h26, 32'h8000_0000, 1'b1, 1'b0); // s=38 -> din[31]
    send(32'h0000_0000, 7'h67, 32'h0000_0000, 1'b0, 1'b1); // s=39, p=1
    send(32'h0000_0000, 7'h7F, 32'h0000_0000, 1'b0, 1'b1); // s=63, p=1
    send(32'hFFFF_FFFF, 7'h18, 32'hFFFF_FFFF, 1'b0, 1'b0); // clean
    send(32'hFFFF_FFEF, 7'h18, 32'hFFFF_FFFF, 1'b1, 1'b0); // din[4] flipped
    idle(4);

    // stall mid-stream
    fork
      begin
        send(32'h0000_0000, 7'h00, 32'h0000_0000, 1'b0, 1'b0);
        send(32'h0000_0001, 7'h43, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 7'h18, 32'hFFFF_FFFF, 1'b0, 1'b0);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_in_ready", {33'd0, in_ready}, 34'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);

    // counter clear with a simultaneous increment
    send(32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    idle(2);
    chk("clr_sb", {18'd0, sb_cnt}, 34'd0);

`ifdef RVECC_ERR_CNT_EN
    // saturation
    for (int i = 0; i < 65535; i++) send(32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0);
    idle(3);
    chk("sat_sb", {18'd0, sb_cnt}, {18'd0, 16'hFFFF});
    send(32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0);
    idle(3);
    chk("sat_hold", {18'd0, sb_cnt}, {18'd0, 16'hFFFF});
    send(32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    idle(2);
    chk("sat_clr", {18'd0, sb_cnt}, 34'd0);
`endif

    // reset mid-stream, with in_valid held during reset
    send(32'h0000_0003, 7'h00, 32'h0000_0003, 1'b0, 1'b1);
    din = 32'h0000_0001;
    ecc_in = 7'h00;
    in_valid = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    exp_sb = '0;
    exp_db = '0;
    idle(2);
    rst = 1'b0;
    in_valid = 1'b0;
    check_reset_state("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_quiet", {33'd0, out_valid}, 34'd0);
    end

    // one more word after reset, then drain
    idle(1);
    send(32'h0000_0000, 7'h40, 32'h0000_0000, 1'b1, 1'b0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", {2'd0, 32'(exp_q.size())}, 34'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rvecc_decode_pipe.md
RVECC_DECODE_PIPE -- requirements
Module: rvecc_decode_pipe

Interface
REQ-001 Parameter: CNT_W, 16, width of each error counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  codeword presented on din/ecc_in.
REQ-005 in_ready  output  1  block accepts codeword this cycle.
REQ-006 din  input  32  received data bits.
REQ-007 ecc_in  input  7  received check bits; [5:0] Hamming, [6] overall parity.
REQ-008 out_valid  output  1  corrected result available.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 dout  output  32  corrected data.
REQ-011 single_ecc_error  output  1  qualified by out_valid; single-bit error corrected.
REQ-012 double_ecc_error  output  1  qualified by out_valid; uncorrectable error, dout = din unmodified.
REQ-013 cnt_clr  input  1  synchronous clear of both counters.
REQ-014 sb_cnt  output  CNT_W  saturating count of single-error transfers.
REQ-015 db_cnt  output  CNT_W  saturating count of double-error transfers.

Function
REQ-016 Code layout: the 38 Hamming positions 1..38; check bit k at position 2^k (k=0..5); data bits din[0..31] in ascending order at the remaining positions (din[0]=3, din[1]=5, din[2]=6, din[3]=7, din[4]=9, ..., din[31]=38).
REQ-017 Check bit k = XOR of data bits whose position has bit k set; ecc[6] = XOR of din[31:0] and ecc[5:0].
REQ-018 Syndrome s[5:0] = recomputed check bits XOR ecc_in[5:0]; p = XOR of din, ecc_in[6:0] (1 = parity mismatch).
REQ-019 s==0, p==0: no error, dout=din, both flags 0.
REQ-020 p==1, s==0: error in ecc_in[6]; dout=din, single=1.
REQ-021 p==1, 1<=s<=38: flip bit at position s (data bit if data position, else check bit only); single=1.
REQ-022 p==1, s>38: double=1, single=0, dout=din.
REQ-023 p==0, s!=0: double=1, single=0, dout=din.
REQ-024 Pipeline: stage 1 registers din and s/p; stage 2 registers dout and flags; latency exactly 2 cycles from input transfer to out_valid with no stall.
REQ-025 Stage 2 loads when !out_valid or out_ready; stage 1 loads when stage 1 empty or stage 2 loads.
REQ-026 in_ready = stage 1 empty or stage 2 loads (combinational from out_ready permitted); full throughput of one word/cycle when out_ready held high.
REQ-027 While out_valid && !out_ready, dout and flags hold stable; no word dropped or duplicated.
REQ-028 Input transfer = in_valid && in_ready; output transfer = out_valid && out_ready; order preserved.
REQ-029 Counters increment by 1 only on output transfer with the corresponding flag; saturate at 2^CNT_W-1.
REQ-030 cnt_clr sets both counters to 0 next cycle; wins over a simultaneous increment.

Reset
REQ-031 rst high at a rising edge empties both stages: out_valid=0, stage-1 valid=0, in_ready=1 next cycle.
REQ-032 rst clears sb_cnt, db_cnt, single_ecc_error, double_ecc_error, dout to 0.
REQ-033 rst mid-stream discards in-flight words; no output transfer occurs for them.
REQ-034 in_valid during rst-high cycles is ignored.

Configuration
REQ-035 Macro RVECC_ERR_CNT_EN: defined -> counters and cnt_clr behave per REQ-029/030.
REQ-036 Not defined -> no counter flops; sb_cnt, db_cnt tied to 0; cnt_clr ignored; decode and pipeline unchanged.

Verification
REQ-037 din=32'h0, ecc_in=7'h00, out_ready=1 -> 2 cycles later dout=32'h0, both flags 0.
REQ-038 din=32'h1, ecc_in=7'h00 (din[0] flipped from 0) -> dout=32'h0, single=1, sb_cnt 0->1.
REQ-039 din=32'h3, ecc_in=7'h00 -> s=6, p=0 -> double=1, dout=32'h3, db_cnt 0->1.
REQ-040 din=32'h0, ecc_in=7'h40 -> dout=32'h0, single=1; din=32'h1, ecc_in=7'h43 -> no error.
REQ-041 Stream 4 words, out_ready low 3 cycles mid-stream -> in_ready drops, dout held, all 4 delivered in order.
REQ-042 sb_cnt preloaded to 16'hFFFF via repeated single errors plus cnt_clr in same cycle as increment -> counter 0; without cnt_clr stays 16'hFFFF.
